// File: rtl/gate_pkg.sv
// Shared encodings for the parking-lot barrier arbiter: controller states,
// lane identifiers and the factory entry PIN.
package gate_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENTRY_PIN  = 3'd1,
    ENTRY_OPEN = 3'd2,
    EXIT_OPEN  = 3'd3,
    BLOCKED    = 3'd4
  } gate_state_e;

  typedef enum logic {
    GRANT_ENTRY = 1'b0,
    GRANT_EXIT  = 1'b1
  } lane_e;

  localparam logic [7:0] DEFAULT_PIN = 8'b0010_0110;

  // States that are abandoned if they last too long.
  function automatic logic is_timed(input gate_state_e s);
    return (s == ENTRY_PIN) || (s == ENTRY_OPEN) || (s == EXIT_OPEN);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; expire flags the cycle whose decrement reaches zero,
// so a loaded state lasts exactly OPEN_TIMEOUT cycles.
module gate_timer #(
  parameter int OPEN_TIMEOUT = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [W-1:0] LOAD_V = W'(OPEN_TIMEOUT);
  localparam logic [W-1:0] ONE_V  = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: reload on state entry, otherwise count down while armed.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_V;
    end else if (en && (count_q != {W{1'b0}})) begin
      count_d = count_q - ONE_V;
    end else begin
      count_d = count_q;
    end
  end

  assign expire = en && (count_q == ONE_V);

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gate_lane_arbiter.sv
// Shares one barrier drive between the entry and exit lanes of a parking lot:
// PIN-gated entry, free exit, occupancy tracking and block/PIN/timeout alarms.
module gate_lane_arbiter
  import gate_pkg::*;
#(
  parameter int         CAPACITY     = 8,
  parameter int         CNT_W        = 4,
  parameter logic [7:0] PIN          = DEFAULT_PIN,
  parameter int         MAX_TRIES    = 3,
  parameter int         OPEN_TIMEOUT = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entrySensorA,
  input  logic             entrySensorB,
  input  logic             exitSensorA,
  input  logic             exitSensorB,
  input  logic [7:0]       pass,
  input  logic             passValid,
  output logic             gateEntryOpen,
  output logic             gateExitOpen,
  output logic             blockAlarm,
  output logic             wrongPinAlarm,
  output logic             timeoutAlarm,
  output logic             full,
  output logic [CNT_W-1:0] occupancy
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] OCC_ONE   = CNT_W'(1);
  localparam logic [TRY_W-1:0] TRY_MAX_V = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);

  gate_state_e      state_q, state_d;
  lane_e            last_q, last_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             entry_open_q, entry_open_d;
  logic             exit_open_q, exit_open_d;
  logic             block_q, block_d;
  logic             wrong_q, wrong_d;
  logic             timeout_q, timeout_d;
  logic             full_q, full_d;

  logic entry_req_s, exit_req_s, pin_ok_s, pin_bad_s;
  logic tmr_load_s, tmr_en_s, tmr_expire_s;

  assign entry_req_s = entrySensorA & ~full_q;
  assign exit_req_s  = exitSensorA & (occ_q != {CNT_W{1'b0}});
  assign pin_ok_s    = passValid & (pass == PIN);
  assign pin_bad_s   = passValid & (pass != PIN);
  assign tmr_en_s    = is_timed(state_q);
  assign tmr_load_s  = is_timed(state_d) & (state_d != state_q);

  gate_timer #(.OPEN_TIMEOUT(OPEN_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load_s),
    .en     (tmr_en_s),
    .expire (tmr_expire_s)
  );

  // Next-state, bookkeeping and registered-output values.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    occ_d     = occ_q;
    tries_d   = tries_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (entry_req_s && exit_req_s) begin
          state_d = (last_q == GRANT_EXIT) ? ENTRY_PIN : EXIT_OPEN;
        end else if (entry_req_s) begin
          state_d = ENTRY_PIN;
        end else if (exit_req_s) begin
          state_d = EXIT_OPEN;
        end else begin
          state_d = IDLE;
        end
      end
      ENTRY_PIN: begin
        if (pin_bad_s && (tries_q != TRY_MAX_V)) begin
          tries_d = tries_q + TRY_ONE;
        end else begin
          tries_d = tries_q;
        end
        if (pin_ok_s) begin
          state_d = ENTRY_OPEN;
          tries_d = {TRY_W{1'b0}};
        end else if (!entrySensorA) begin
          state_d = IDLE;
        end else if (tmr_expire_s) begin
          // Hand priority to a waiting exit after an abandoned PIN wait.
          state_d   = IDLE;
          timeout_d = 1'b1;
          last_d    = GRANT_ENTRY;
        end else begin
          state_d = ENTRY_PIN;
        end
      end
      ENTRY_OPEN: begin
        if (entrySensorB && !entrySensorA) begin
          if (occ_q != CAP_V) begin
            occ_d = occ_q + OCC_ONE;
          end else begin
            occ_d = occ_q;
          end
          last_d  = GRANT_ENTRY;
          state_d = IDLE;
        end else if (entrySensorB && entrySensorA) begin
          state_d = BLOCKED;
        end else if (tmr_expire_s) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          state_d = ENTRY_OPEN;
        end
      end
      EXIT_OPEN: begin
        if (exitSensorB && !exitSensorA) begin
          if (occ_q != {CNT_W{1'b0}}) begin
            occ_d = occ_q - OCC_ONE;
          end else begin
            occ_d = occ_q;
          end
          last_d  = GRANT_EXIT;
          state_d = IDLE;
        end else if (exitSensorB && exitSensorA) begin
          state_d = BLOCKED;
        end else if (tmr_expire_s) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          state_d = EXIT_OPEN;
        end
      end
      BLOCKED: begin
        if (pin_ok_s) begin
          state_d = IDLE;
          tries_d = {TRY_W{1'b0}};
        end else begin
          state_d = BLOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    entry_open_d = (state_d == ENTRY_OPEN);
    exit_open_d  = (state_d == EXIT_OPEN);
    block_d      = (state_d == BLOCKED);
    wrong_d      = (tries_d == TRY_MAX_V);
    full_d       = (occ_d == CAP_V);
  end

  // State and output registers; reset drops both barriers immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_q       <= GRANT_EXIT;
      occ_q        <= {CNT_W{1'b0}};
      tries_q      <= {TRY_W{1'b0}};
      entry_open_q <= 1'b0;
      exit_open_q  <= 1'b0;
      block_q      <= 1'b0;
      wrong_q      <= 1'b0;
      timeout_q    <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      occ_q        <= occ_d;
      tries_q      <= tries_d;
      entry_open_q <= entry_open_d;
      exit_open_q  <= exit_open_d;
      block_q      <= block_d;
      wrong_q      <= wrong_d;
      timeout_q    <= timeout_d;
      full_q       <= full_d;
    end
  end

  assign gateEntryOpen = entry_open_q;
  assign gateExitOpen  = exit_open_q;
  assign blockAlarm    = block_q;
  assign wrongPinAlarm = wrong_q;
  assign timeoutAlarm  = timeout_q;
  assign full          = full_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Bench for gate_lane_arbiter: directed lane scenarios with hand-computed
// expectations, then randomized sensor/keypad traffic against a lot model.
module tb_gate_lane_arbiter;

  localparam int         CAP   = 8;
  localparam int         CW    = 4;
  localparam int         TRIES = 3;
  localparam int         TMO   = 50;
  localparam logic [7:0] PIN_C = 8'h26;

  localparam int WAIT_CAR = 10;
  localparam int WAIT_PIN = 20;
  localparam int IN_OPEN  = 30;
  localparam int OUT_OPEN = 40;
  localparam int JAMMED   = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          entrySensorA = 1'b0, entrySensorB = 1'b0;
  logic          exitSensorA = 1'b0, exitSensorB = 1'b0;
  logic [7:0]    pass = 8'h00;
  logic          passValid = 1'b0;
  logic          gateEntryOpen, gateExitOpen, blockAlarm, wrongPinAlarm;
  logic          timeoutAlarm, full;
  logic [CW-1:0] occupancy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  gate_lane_arbiter #(
    .CAPACITY(CAP), .CNT_W(CW), .PIN(PIN_C), .MAX_TRIES(TRIES), .OPEN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .entrySensorA(entrySensorA), .entrySensorB(entrySensorB),
    .exitSensorA(exitSensorA), .exitSensorB(exitSensorB),
    .pass(pass), .passValid(passValid),
    .gateEntryOpen(gateEntryOpen), .gateExitOpen(gateExitOpen),
    .blockAlarm(blockAlarm), .wrongPinAlarm(wrongPinAlarm),
    .timeoutAlarm(timeoutAlarm), .full(full), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  wire [CW+5:0] outs_v = {gateEntryOpen, gateExitOpen, blockAlarm, wrongPinAlarm,
                          timeoutAlarm, full, occupancy};

  // Lot model: what lane is being served, how long it has been served,
  // cars in the lot, consecutive bad PINs and which lane finished last.
  typedef struct {
    int mode;
    int elapsed;
    int occ;
    int tries;
    bit last_entry;
    bit timeout;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = WAIT_CAR; r.elapsed = 0; r.occ = 0; r.tries = 0;
    r.last_entry = 1'b0; r.timeout = 1'b0;
    return r;
  endfunction

  function automatic mdl_t model_next(input mdl_t s);
    mdl_t n;
    bit ok, bad, expired, want_in, want_out;
    n = s;
    n.timeout = 1'b0;
    ok      = passValid && (pass == PIN_C);
    bad     = passValid && (pass != PIN_C);
    expired = (s.elapsed + 1 >= TMO);
    case (s.mode)
      WAIT_CAR: begin
        want_in  = entrySensorA && (s.occ < CAP);
        want_out = exitSensorA && (s.occ > 0);
        if (want_in && (!want_out || !s.last_entry)) n.mode = WAIT_PIN;
        else if (want_out) n.mode = OUT_OPEN;
      end
      WAIT_PIN: begin
        if (bad && s.tries < TRIES) n.tries = s.tries + 1;
        if (ok) begin n.mode = IN_OPEN; n.tries = 0; end
        else if (!entrySensorA) n.mode = WAIT_CAR;
        else if (expired) begin n.mode = WAIT_CAR; n.timeout = 1'b1; n.last_entry = 1'b1; end
      end
      IN_OPEN: begin
        if (entrySensorB && !entrySensorA) begin
          if (s.occ < CAP) n.occ = s.occ + 1;
          n.last_entry = 1'b1; n.mode = WAIT_CAR;
        end else if (entrySensorB && entrySensorA) n.mode = JAMMED;
        else if (expired) begin n.mode = WAIT_CAR; n.timeout = 1'b1; end
      end
      OUT_OPEN: begin
        if (exitSensorB && !exitSensorA) begin
          if (s.occ > 0) n.occ = s.occ - 1;
          n.last_entry = 1'b0; n.mode = WAIT_CAR;
        end else if (exitSensorB && exitSensorA) n.mode = JAMMED;
        else if (expired) begin n.mode = WAIT_CAR; n.timeout = 1'b1; end
      end
      default: begin
        if (ok) begin n.mode = WAIT_CAR; n.tries = 0; end
      end
    endcase
    n.elapsed = (n.mode != s.mode) ? 0 : s.elapsed + 1;
    return n;
  endfunction

  function automatic logic [CW+5:0] model_outs(input mdl_t s);
    return {s.mode == IN_OPEN, s.mode == OUT_OPEN, s.mode == JAMMED, s.tries >= TRIES,
            s.timeout, s.occ == CAP, CW'(s.occ)};
  endfunction

  mdl_t m = mdl_reset();

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= mdl_reset();
    else        m <= model_next(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock: inputs set before the call cross the next rising edge, outputs
  // are compared against the model on the following falling edge.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      check("model", 32'(outs_v), 32'(model_outs(m)));
      check("mutex", 32'(gateEntryOpen & gateExitOpen), 32'd0);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    pass = v; passValid = 1'b1;
    step();
    passValid = 1'b0;
  endtask

  function automatic logic flip(input logic v, input int div);
    return v ^ ($urandom_range(0, div - 1) == 0);
  endfunction

  initial begin
    int n;
    int ea_div[4] = '{8, 6, 40, 60};
    int xa_div[4] = '{8, 400, 40, 4};
    int b_div[4]  = '{8, 5, 40, 5};
    int pv_div[4] = '{6, 4, 60, 6};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    step();
    check("reset_outputs", 32'(outs_v), 32'd0);

    // Entry with correct PIN.
    entrySensorA = 1'b1; step();
    check("pin_wait_gate_closed", 32'(gateEntryOpen), 32'd0);
    strobe(8'b0010_0110);
    check("entry_open", 32'(gateEntryOpen), 32'd1);
    entrySensorA = 1'b0; entrySensorB = 1'b1; step();
    check("entry_closed", 32'(gateEntryOpen), 32'd0);
    check("occ_after_entry", 32'(occupancy), 32'd1);
    entrySensorB = 1'b0; step();

    // Three wrong PINs raise the alarm, the right one clears it.
    entrySensorA = 1'b1; step();
    strobe(8'hFF);
    strobe(8'h3E);
    check("wrong_pin_two", 32'(wrongPinAlarm), 32'd0);
    strobe(8'hFF);
    check("wrong_pin_three", 32'(wrongPinAlarm), 32'd1);
    strobe(8'h26);
    check("wrong_pin_cleared", 32'(wrongPinAlarm), 32'd0);
    check("open_after_retry", 32'(gateEntryOpen), 32'd1);
    entrySensorA = 1'b0; entrySensorB = 1'b1; step();
    entrySensorB = 1'b0; step();
    check("occ_two", 32'(occupancy), 32'd2);

    // Open gate abandoned after the timeout.
    entrySensorA = 1'b1; step();
    strobe(8'h26);
    entrySensorA = 1'b0;
    n = 0;
    while (gateEntryOpen && n < 200) begin
      step();
      n++;
    end
    check("open_cycles", 32'(n), 32'd50);
    check("timeout_pulse", 32'(timeoutAlarm), 32'd1);
    check("occ_after_timeout", 32'(occupancy), 32'd2);
    step();
    check("timeout_one_cycle", 32'(timeoutAlarm), 32'd0);

    // Tailgating blocks until the right PIN.
    entrySensorA = 1'b1; step();
    strobe(8'h26);
    entrySensorB = 1'b1; step();
    check("block_alarm", 32'(blockAlarm), 32'd1);
    check("block_gates", 32'({gateEntryOpen, gateExitOpen}), 32'd0);
    entrySensorA = 1'b0; entrySensorB = 1'b0;
    strobe(8'h00);
    check("block_wrong_pin", 32'(blockAlarm), 32'd1);
    check("block_no_tries", 32'(wrongPinAlarm), 32'd0);
    strobe(8'h26);
    check("block_cleared", 32'(blockAlarm), 32'd0);
    check("occ_after_block", 32'(occupancy), 32'd2);

    // Exit opens, then an asynchronous reset drops everything mid-cycle.
    exitSensorA = 1'b1; step();
    check("exit_open", 32'(gateExitOpen), 32'd1);
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(outs_v), 32'd0);
    exitSensorA = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Randomized traffic with per-phase sensor and keypad activity.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 3000; c++) begin
        entrySensorA = flip(entrySensorA, ea_div[ph]);
        entrySensorB = flip(entrySensorB, b_div[ph]);
        exitSensorA  = (ph == 1) ? 1'b0 : flip(exitSensorA, xa_div[ph]);
        exitSensorB  = flip(exitSensorB, b_div[ph]);
        passValid    = ($urandom_range(0, pv_div[ph] - 1) == 0);
        pass         = $urandom_range(0, 1) ? PIN_C : 8'($urandom_range(0, 255));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_lane_arbiter.md
Name: gate_lane_arbiter

Overview:
Parking-lot access scheduler that shares one barrier drive between an entry lane and an exit lane, so only one barrier is open at any time. Entry requires an 8-bit PIN. Exit needs no PIN. The block tracks lot occupancy, refuses entry when the lot is full, and raises block, wrong-PIN and timeout alarms. It sits between the lane sensors/keypad and the two barrier actuators.

Parameters:
CAPACITY, 8, maximum cars in lot; entry is refused when occupancy == CAPACITY
CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > CAPACITY
PIN, 8'b00100110, accepted entry PIN
MAX_TRIES, 3, consecutive wrong PINs before wrongPinAlarm asserts
OPEN_TIMEOUT, 50, cycles a barrier or PIN wait may last before it is abandoned (10 s at 200 ms clock)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
entrySensorA  in  1  car waiting at entry barrier
entrySensorB  in  1  car inside, past entry barrier
exitSensorA  in  1  car waiting at exit barrier
exitSensorB  in  1  car outside, past exit barrier
pass  in  8  keypad PIN value
passValid  in  1  one-cycle strobe; pass is valid this cycle
gateEntryOpen  out  1  entry barrier open command
gateExitOpen  out  1  exit barrier open command
blockAlarm  out  1  tailgating/blocked condition
wrongPinAlarm  out  1  MAX_TRIES consecutive wrong PINs
timeoutAlarm  out  1  one-cycle pulse when a grant is abandoned
full  out  1  occupancy == CAPACITY
occupancy  out  CNT_W  cars currently in lot

Behaviour:
- Reset (reset = 0, asynchronous):
  - All outputs are 0; occupancy = 0.
  - State = IDLE; tries = 0; lastGrant = EXIT, so entry wins the first tie.
- All outputs are registered and update on the same edge as the state change.
- Requests are evaluated in IDLE only:
  - entryReq = entrySensorA & !full.
  - exitReq = exitSensorA & (occupancy != 0).
- IDLE:
  - Only entryReq -> ENTRY_PIN. Only exitReq -> EXIT_OPEN.
  - Both -> grant the lane opposite to lastGrant (round-robin).
  - Neither -> stay.
- ENTRY_PIN: timer is loaded with OPEN_TIMEOUT on entry to this state.
  - passValid & pass == PIN -> ENTRY_OPEN; tries = 0; wrongPinAlarm cleared.
  - passValid & pass != PIN -> tries++, saturating at MAX_TRIES; wrongPinAlarm = 1 once tries reaches MAX_TRIES; stay in state.
  - entrySensorA falls -> IDLE; tries kept.
  - Timer expiry -> IDLE, timeoutAlarm pulse, lastGrant = ENTRY; a waiting exit is served next.
- ENTRY_OPEN: gateEntryOpen = 1; timer is reloaded.
  - entrySensorB & !entrySensorA -> occupancy++, gateEntryOpen = 0, lastGrant = ENTRY, IDLE.
  - entrySensorB & entrySensorA -> BLOCKED (second car tailgating).
  - Timer expiry -> close, timeoutAlarm pulse, IDLE, no count change.
- EXIT_OPEN: gateExitOpen = 1; timer is reloaded.
  - exitSensorB & !exitSensorA -> occupancy--, close, lastGrant = EXIT, IDLE.
  - exitSensorB & exitSensorA -> BLOCKED.
  - Timer expiry -> close, timeoutAlarm pulse, IDLE.
- BLOCKED: both gates closed; blockAlarm = 1.
  - Leaves only on passValid & pass == PIN -> IDLE; blockAlarm cleared; tries = 0.
  - Wrong PINs here do not change tries.
- Mutual exclusion: gateEntryOpen & gateExitOpen is never 1 in the same cycle.
- Occupancy:
  - Never exceeds CAPACITY and never underflows; the request gating guarantees this, and RTL also saturates.
  - full is combinationally derived from the registered occupancy, then registered with it.
- The timer counts down one per cycle while armed; expiry is the cycle the count reaches 0.
- passValid outside ENTRY_PIN/BLOCKED is ignored.
- Reset mid-operation closes both gates immediately, asynchronously, and clears occupancy.

Decomposition:
- Shared package gate_pkg:
  - State encoding localparams (IDLE, ENTRY_PIN, ENTRY_OPEN, EXIT_OPEN, BLOCKED).
  - Lane grant encoding (ENTRY/EXIT).
  - Default PIN constant.
- One sub-module gate_timer:
  - Loadable down-counter with load, enable and expire.
  - Width $clog2(OPEN_TIMEOUT+1).
  - Instantiated once; reloaded on each state entry.

Test Plan:
- Entry, correct PIN: reset, entrySensorA = 1, passValid with pass = 8'b00100110 -> gateEntryOpen = 1 on that edge; then A = 0, B = 1 -> gate closes, occupancy 0 -> 1.
- Wrong PIN: pass = 8'hFF, then 8'h3E, then 8'hFF, each strobed -> wrongPinAlarm = 1 after the third; then pass = 8'h26 -> alarm 0, gate opens.
- Tie: occupancy = 2, entrySensorA and exitSensorA raised on the same cycle after reset -> entry served first; after entry completes, exit is served (gateExitOpen = 1), occupancy 3 -> 2.
- Tailgate: during ENTRY_OPEN drive A = 1 and B = 1 -> blockAlarm = 1, both gates 0; wrong PIN keeps the alarm; correct PIN -> IDLE with alarm 0; occupancy unchanged.
- Full/empty: with CAPACITY = 2, two entries complete -> full = 1; entrySensorA = 1 stays in IDLE. With occupancy 0, exitSensorA = 1 -> no grant.
- Timeout and reset:
  - Open entry gate, hold sensors idle 50 cycles -> timeoutAlarm pulses exactly 1 cycle; gate closes; occupancy unchanged.
  - Assert reset with gateExitOpen = 1 -> outputs 0 asynchronously.
